// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode fields, forwarding sources and EX outputs.
// Decode and the forwarding network drive the master side; the stage is the slave.
interface id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic            ID_VALID;
  logic [XLEN-1:0] ID_PC;
  logic [4:0]      ID_RS1;
  logic [4:0]      ID_RS2;
  logic [4:0]      ID_RD;
  logic            ID_USE_RS1;
  logic            ID_USE_RS2;
  logic [XLEN-1:0] ID_RS1_DATA;
  logic [XLEN-1:0] ID_RS2_DATA;
  logic [XLEN-1:0] ID_IMM;
  logic [4:0]      ID_ALUOP;
  logic            ID_OP1_SEL;
  logic            ID_OP2_SEL;
  logic            ID_REG_WRITE;
  logic            ID_MEM_READ;
  logic            ID_MEM_WRITE;
  logic [4:0]      EXMEM_RD;
  logic            EXMEM_REG_WRITE;
  logic [XLEN-1:0] EXMEM_RESULT;
  logic [4:0]      MEMWB_RD;
  logic            MEMWB_REG_WRITE;
  logic [XLEN-1:0] MEMWB_DATA;
  logic            FLUSH;
  logic            STALL_OUT;
  logic            EX_VALID;
  logic [XLEN-1:0] EX_DATA1;
  logic [XLEN-1:0] EX_DATA2;
  logic [4:0]      EX_SELECT;
  logic [XLEN-1:0] EX_STORE_DATA;
  logic [XLEN-1:0] EX_PC;
  logic [4:0]      EX_RD;
  logic            EX_REG_WRITE;
  logic            EX_MEM_READ;
  logic            EX_MEM_WRITE;
  logic [CNT_W-1:0] STALL_CNT;

  modport master (
    output ID_VALID, ID_PC, ID_RS1, ID_RS2, ID_RD,
    output ID_USE_RS1, ID_USE_RS2, ID_RS1_DATA, ID_RS2_DATA,
    output ID_IMM, ID_ALUOP, ID_OP1_SEL, ID_OP2_SEL,
    output ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE,
    output EXMEM_RD, EXMEM_REG_WRITE, EXMEM_RESULT,
    output MEMWB_RD, MEMWB_REG_WRITE, MEMWB_DATA, FLUSH,
    input  STALL_OUT, EX_VALID, EX_DATA1, EX_DATA2,
    input  EX_SELECT, EX_STORE_DATA, EX_PC, EX_RD,
    input  EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE, STALL_CNT
  );

  modport slave (
    input  ID_VALID, ID_PC, ID_RS1, ID_RS2, ID_RD,
    input  ID_USE_RS1, ID_USE_RS2, ID_RS1_DATA, ID_RS2_DATA,
    input  ID_IMM, ID_ALUOP, ID_OP1_SEL, ID_OP2_SEL,
    input  ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE,
    input  EXMEM_RD, EXMEM_REG_WRITE, EXMEM_RESULT,
    input  MEMWB_RD, MEMWB_REG_WRITE, MEMWB_DATA, FLUSH,
    output STALL_OUT, EX_VALID, EX_DATA1, EX_DATA2,
    output EX_SELECT, EX_STORE_DATA, EX_PC, EX_RD,
    output EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE, STALL_CNT
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding,
// load-use stall detection and branch-flush squashing.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic        CLK,
  input logic        RESET_N,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      aluop;
    logic            op1_sel;
    logic            op2_sel;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } id_ex_t;

  id_ex_t           r_q;
  id_ex_t           w_ld;
  logic [CNT_W-1:0] r_cnt;
  logic             w_hit1;
  logic             w_hit2;
  logic             w_stall;
  logic [XLEN-1:0]  w_fwd1;
  logic [XLEN-1:0]  w_fwd2;

  always_comb begin
    w_hit1  = bus.ID_USE_RS1 && (bus.ID_RS1 == r_q.rd);
    w_hit2  = bus.ID_USE_RS2 && (bus.ID_RS2 == r_q.rd);
    w_stall = r_q.valid && r_q.mem_read && (r_q.rd != 5'd0)
           && bus.ID_VALID && (w_hit1 || w_hit2);
  end

  // Flush and stall both load an all-zero bubble.
  always_comb begin
    w_ld = '0;
    if (!bus.FLUSH && !w_stall) begin
      w_ld.valid     = bus.ID_VALID;
      w_ld.pc        = bus.ID_PC;
      w_ld.rs1       = bus.ID_RS1;
      w_ld.rs2       = bus.ID_RS2;
      w_ld.rd        = bus.ID_RD;
      w_ld.rs1_data  = bus.ID_RS1_DATA;
      w_ld.rs2_data  = bus.ID_RS2_DATA;
      w_ld.imm       = bus.ID_IMM;
      w_ld.aluop     = bus.ID_ALUOP;
      w_ld.op1_sel   = bus.ID_OP1_SEL;
      w_ld.op2_sel   = bus.ID_OP2_SEL;
      w_ld.reg_write = bus.ID_VALID && bus.ID_REG_WRITE;
      w_ld.mem_read  = bus.ID_VALID && bus.ID_MEM_READ;
      w_ld.mem_write = bus.ID_VALID && bus.ID_MEM_WRITE;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_q   <= '0;
      r_cnt <= '0;
    end else begin
      r_q <= w_ld;
      if (!bus.FLUSH && w_stall && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // EX/MEM has the younger result, so it is checked first.
  always_comb begin
    w_fwd1 = r_q.rs1_data;
    if (bus.EXMEM_REG_WRITE && (bus.EXMEM_RD == r_q.rs1)
        && (r_q.rs1 != 5'd0))
      w_fwd1 = bus.EXMEM_RESULT;
    else if (bus.MEMWB_REG_WRITE && (bus.MEMWB_RD == r_q.rs1)
             && (r_q.rs1 != 5'd0))
      w_fwd1 = bus.MEMWB_DATA;
  end

  always_comb begin
    w_fwd2 = r_q.rs2_data;
    if (bus.EXMEM_REG_WRITE && (bus.EXMEM_RD == r_q.rs2)
        && (r_q.rs2 != 5'd0))
      w_fwd2 = bus.EXMEM_RESULT;
    else if (bus.MEMWB_REG_WRITE && (bus.MEMWB_RD == r_q.rs2)
             && (r_q.rs2 != 5'd0))
      w_fwd2 = bus.MEMWB_DATA;
  end

  assign bus.STALL_OUT     = w_stall;
  assign bus.EX_VALID      = r_q.valid;
  assign bus.EX_DATA1      = r_q.op1_sel ? r_q.pc  : w_fwd1;
  assign bus.EX_DATA2      = r_q.op2_sel ? r_q.imm : w_fwd2;
  assign bus.EX_STORE_DATA = w_fwd2;
  assign bus.EX_SELECT     = r_q.aluop;
  assign bus.EX_PC         = r_q.pc;
  assign bus.EX_RD         = r_q.rd;
  assign bus.EX_REG_WRITE  = r_q.valid && r_q.reg_write;
  assign bus.EX_MEM_READ   = r_q.valid && r_q.mem_read;
  assign bus.EX_MEM_WRITE  = r_q.valid && r_q.mem_write;
  assign bus.STALL_CNT     = r_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by random
// traffic, all checked against an instruction-slot model.
module tb_id_ex_stage;

  logic CLK = 1'b0;
  logic RESET_N;
  int   n_cmp = 0;
  int   n_bad = 0;

  id_ex_stage_if #(.XLEN(32), .CNT_W(16)) bus ();

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          valid;
    bit [31:0]   pc, d1, d2, imm;
    bit [4:0]    rs1, rs2, rd, op;
    bit          s1, s2, rw, mr, mw;
  } slot_t;

  slot_t     m;
  bit [15:0] m_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] efwd(input bit [4:0] rs,
                                     input bit [31:0] rf);
    if (rs == 0) return rf;
    if (bus.EXMEM_REG_WRITE && bus.EXMEM_RD == rs)
      return bus.EXMEM_RESULT;
    if (bus.MEMWB_REG_WRITE && bus.MEMWB_RD == rs)
      return bus.MEMWB_DATA;
    return rf;
  endfunction

  // The younger ID instruction needs a register the load in EX will produce.
  function automatic bit exp_stall();
    bit dep;
    dep = (bus.ID_USE_RS1 && bus.ID_RS1 == m.rd)
       || (bus.ID_USE_RS2 && bus.ID_RS2 == m.rd);
    return m.valid && m.mr && m.rd != 0 && bus.ID_VALID && dep;
  endfunction

  task automatic check_all();
    chk("stall_out", bus.STALL_OUT, exp_stall());
    chk("ex_valid", bus.EX_VALID, m.valid);
    chk("data1", bus.EX_DATA1, m.s1 ? m.pc : efwd(m.rs1, m.d1));
    chk("data2", bus.EX_DATA2, m.s2 ? m.imm : efwd(m.rs2, m.d2));
    chk("store", bus.EX_STORE_DATA, efwd(m.rs2, m.d2));
    chk("select", bus.EX_SELECT, m.op);
    chk("pc", bus.EX_PC, m.pc);
    chk("rd", bus.EX_RD, m.rd);
    chk("reg_write", bus.EX_REG_WRITE, m.valid && m.rw);
    chk("mem_read", bus.EX_MEM_READ, m.valid && m.mr);
    chk("mem_write", bus.EX_MEM_WRITE, m.valid && m.mw);
    chk("stall_cnt", bus.STALL_CNT, m_cnt);
  endtask

  task automatic model_edge();
    slot_t n;
    bit    st;
    n  = '{default: '0};
    st = exp_stall();
    if (!RESET_N) begin
      m_cnt = 0;
    end else if (bus.FLUSH) begin
      // squashed: empty slot, counter untouched
    end else if (st) begin
      if (m_cnt != 16'hFFFF) m_cnt++;
    end else begin
      n.valid = bus.ID_VALID;
      n.pc = bus.ID_PC;  n.rs1 = bus.ID_RS1; n.rs2 = bus.ID_RS2;
      n.rd = bus.ID_RD;  n.d1 = bus.ID_RS1_DATA;
      n.d2 = bus.ID_RS2_DATA; n.imm = bus.ID_IMM;
      n.op = bus.ID_ALUOP; n.s1 = bus.ID_OP1_SEL;
      n.s2 = bus.ID_OP2_SEL;
      n.rw = bus.ID_VALID && bus.ID_REG_WRITE;
      n.mr = bus.ID_VALID && bus.ID_MEM_READ;
      n.mw = bus.ID_VALID && bus.ID_MEM_WRITE;
    end
    m = n;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    #1;
    check_all();
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic clear_in();
    bus.ID_VALID = 0; bus.ID_PC = 0; bus.ID_RS1 = 0;
    bus.ID_RS2 = 0; bus.ID_RD = 0; bus.ID_USE_RS1 = 0;
    bus.ID_USE_RS2 = 0; bus.ID_RS1_DATA = 0;
    bus.ID_RS2_DATA = 0; bus.ID_IMM = 0; bus.ID_ALUOP = 0;
    bus.ID_OP1_SEL = 0; bus.ID_OP2_SEL = 0;
    bus.ID_REG_WRITE = 0; bus.ID_MEM_READ = 0;
    bus.ID_MEM_WRITE = 0; bus.EXMEM_RD = 0;
    bus.EXMEM_REG_WRITE = 0; bus.EXMEM_RESULT = 0;
    bus.MEMWB_RD = 0; bus.MEMWB_REG_WRITE = 0;
    bus.MEMWB_DATA = 0; bus.FLUSH = 0;
  endtask

  task automatic load_lw7();
    clear_in();
    bus.ID_VALID = 1; bus.ID_PC = 32'h40; bus.ID_RS1 = 1;
    bus.ID_USE_RS1 = 1; bus.ID_RD = 7; bus.ID_OP2_SEL = 1;
    bus.ID_IMM = 4; bus.ID_MEM_READ = 1; bus.ID_REG_WRITE = 1;
    tick();
    clear_in();
  endtask

  task automatic set_add8();
    bus.ID_VALID = 1; bus.ID_PC = 32'h44; bus.ID_RS1 = 7;
    bus.ID_RS2 = 2; bus.ID_USE_RS1 = 1; bus.ID_USE_RS2 = 1;
    bus.ID_RD = 8; bus.ID_REG_WRITE = 1;
    bus.ID_RS1_DATA = 32'hDEAD; bus.ID_RS2_DATA = 5;
  endtask

  initial begin
    m = '{default: '0};
    m_cnt = 0;
    RESET_N = 0;
    clear_in();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    check_all();
    chk("rst_valid", bus.EX_VALID, 0);
    RESET_N = 1;

    // ADDI x5, x1, 12
    bus.ID_VALID = 1; bus.ID_PC = 32'h10; bus.ID_RS1 = 1;
    bus.ID_USE_RS1 = 1; bus.ID_RD = 5; bus.ID_RS1_DATA = 100;
    bus.ID_IMM = 12; bus.ID_OP2_SEL = 1; bus.ID_REG_WRITE = 1;
    tick();
    chk("addi_d1", bus.EX_DATA1, 100);
    chk("addi_d2", bus.EX_DATA2, 12);
    chk("addi_sel", bus.EX_SELECT, 0);
    chk("addi_rd", bus.EX_RD, 5);

    // forwarding priority on x3
    clear_in();
    bus.ID_VALID = 1; bus.ID_RS1 = 3; bus.ID_USE_RS1 = 1;
    bus.ID_RD = 4; bus.ID_RS1_DATA = 32'h77;
    bus.ID_ALUOP = 5'h03; bus.ID_REG_WRITE = 1;
    tick();
    clear_in();
    bus.EXMEM_RD = 3; bus.EXMEM_REG_WRITE = 1;
    bus.EXMEM_RESULT = 32'hAAAA;
    bus.MEMWB_RD = 3; bus.MEMWB_REG_WRITE = 1;
    bus.MEMWB_DATA = 32'h5555;
    settle();
    chk("fwd_both", bus.EX_DATA1, 32'hAAAA);
    bus.EXMEM_REG_WRITE = 0;
    settle();
    chk("fwd_memwb", bus.EX_DATA1, 32'h5555);
    bus.ID_VALID = 1; bus.ID_RS1 = 0; bus.ID_USE_RS1 = 1;
    bus.ID_RS1_DATA = 32'h99; bus.ID_RD = 1;
    bus.EXMEM_RD = 0; bus.EXMEM_REG_WRITE = 1;
    tick();
    bus.MEMWB_RD = 0;
    settle();
    chk("fwd_x0", bus.EX_DATA1, 32'h99);

    // load-use: LW x7 then ADD x8, x7, x2
    load_lw7();
    set_add8();
    settle();
    chk("lu_stall", bus.STALL_OUT, 1);
    tick();
    chk("lu_bubble", bus.EX_VALID, 0);
    chk("lu_cnt", bus.STALL_CNT, 1);
    chk("lu_release", bus.STALL_OUT, 0);
    bus.MEMWB_RD = 7; bus.MEMWB_REG_WRITE = 1;
    bus.MEMWB_DATA = 32'hBEEF;
    tick();
    chk("lu_fwd", bus.EX_DATA1, 32'hBEEF);
    chk("lu_rs2", bus.EX_DATA2, 5);
    chk("lu_valid", bus.EX_VALID, 1);

    // flush wins over a simultaneous stall
    load_lw7();
    set_add8();
    bus.FLUSH = 1;
    settle();
    chk("fl_stall", bus.STALL_OUT, 1);
    tick();
    chk("fl_valid", bus.EX_VALID, 0);
    chk("fl_cnt", bus.STALL_CNT, 1);
    chk("fl_rw", bus.EX_REG_WRITE, 0);

    // store data forwarded independently of op2_sel
    clear_in();
    bus.ID_VALID = 1; bus.ID_RS1 = 1; bus.ID_RS2 = 9;
    bus.ID_USE_RS1 = 1; bus.ID_USE_RS2 = 1;
    bus.ID_OP2_SEL = 1; bus.ID_IMM = 8;
    bus.ID_MEM_WRITE = 1; bus.ID_RS2_DATA = 32'h42;
    tick();
    clear_in();
    bus.EXMEM_RD = 9; bus.EXMEM_REG_WRITE = 1;
    bus.EXMEM_RESULT = 32'h1234;
    settle();
    chk("sw_d2", bus.EX_DATA2, 8);
    chk("sw_store", bus.EX_STORE_DATA, 32'h1234);
    chk("sw_mw", bus.EX_MEM_WRITE, 1);

    // random traffic over a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      bus.ID_VALID = ($urandom_range(0, 9) < 8);
      bus.ID_PC = $urandom;
      bus.ID_RS1 = 5'($urandom_range(0, 3));
      bus.ID_RS2 = 5'($urandom_range(0, 3));
      bus.ID_RD = 5'($urandom_range(0, 3));
      bus.ID_USE_RS1 = 1'($urandom);
      bus.ID_USE_RS2 = 1'($urandom);
      bus.ID_RS1_DATA = $urandom;
      bus.ID_RS2_DATA = $urandom;
      bus.ID_IMM = $urandom;
      bus.ID_ALUOP = 5'($urandom);
      bus.ID_OP1_SEL = 1'($urandom);
      bus.ID_OP2_SEL = 1'($urandom);
      bus.ID_REG_WRITE = 1'($urandom);
      bus.ID_MEM_READ = ($urandom_range(0, 9) < 4);
      bus.ID_MEM_WRITE = 1'($urandom);
      bus.EXMEM_RD = 5'($urandom_range(0, 3));
      bus.EXMEM_REG_WRITE = 1'($urandom);
      bus.EXMEM_RESULT = $urandom;
      bus.MEMWB_RD = 5'($urandom_range(0, 3));
      bus.MEMWB_REG_WRITE = 1'($urandom);
      bus.MEMWB_DATA = $urandom;
      bus.FLUSH = ($urandom_range(0, 9) == 0);
      settle();
      tick();
    end

    // asynchronous reset mid-stream with non-zero state
    clear_in();
    bus.ID_VALID = 1; bus.ID_ALUOP = 5'h0A; bus.ID_RD = 6;
    bus.ID_REG_WRITE = 1;
    tick();
    chk("pre_rst_sel", bus.EX_SELECT, 5'h0A);
    #2;
    RESET_N = 0;
    #1;
    chk("rst_valid2", bus.EX_VALID, 0);
    chk("rst_sel2", bus.EX_SELECT, 0);
    chk("rst_cnt2", bus.STALL_CNT, 0);
    m = '{default: '0};
    m_cnt = 0;
    check_all();
    tick();
    RESET_N = 1;
    bus.ID_RD = 2;
    tick();
    chk("post_rst_rd", bus.EX_RD, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
